// File: rtl/noblock_obuf.sv
// noblock_obuf: per-output non-blocking buffer of the 4x4 switch.
// A first-word-fall-through FIFO that never back-pressures its writer.
// Words that arrive while it is full are discarded and counted in a
// saturating drop counter. The head word is presented as {valid, data}.
module noblock_obuf #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      IN_WORD,
  input  logic             IN_VALID,
  input  logic             POP,
  output logic [32:0]      NOBLOCKOBUF_OUT,
  output logic             FULL,
  output logic             EMPTY,
  output logic [PTR_W:0]   COUNT,
  output logic [15:0]      DROP_COUNT
);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [15:0]      DROP_MAX  = 16'hFFFF;

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [15:0]      dropCount_q, dropCount_d;

  logic isFull;
  logic isEmpty;
  logic doPop;
  logic doPush;
  logic doDrop;

  assign isFull  = (count_q == CNT_FULL);
  assign isEmpty = (count_q == '0);

  // A pop on a full buffer frees the slot the same cycle, so a write then
  // still goes in; only a write to a full buffer with no pop is dropped.
  assign doPop  = POP && !isEmpty;
  assign doPush = IN_VALID && (!isFull || doPop);
  assign doDrop = IN_VALID && isFull && !doPop;

  // Next-state for pointers, occupancy and the saturating drop counter.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    dropCount_d = dropCount_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (doDrop && (dropCount_q != DROP_MAX)) begin
      dropCount_d = dropCount_q + 16'd1;
    end
  end

  // Control state, cleared asynchronously so the output goes empty at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      dropCount_q <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      dropCount_q <= dropCount_d;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (doPush && !rst) begin
      mem_q[wrPtr_q] <= IN_WORD;
    end
  end

  // Output word and status decoded from registered state only.
  always_comb begin
    NOBLOCKOBUF_OUT = 33'h0;
    if (!isEmpty) begin
      NOBLOCKOBUF_OUT = {1'b1, mem_q[rdPtr_q]};
    end
  end

  assign FULL       = isFull;
  assign EMPTY      = isEmpty;
  assign COUNT      = count_q;
  assign DROP_COUNT = dropCount_q;

endmodule

// File: doc/noblock_obuf.md
# noblock_obuf

Per-output non-blocking buffer of the 4x4 switch: a first-word-fall-through FIFO that accepts 32-bit words from the input side and presents them to the output daemon as a 33-bit {valid, data} word on one of its NOBLOCKOBUF_FROM_n inputs. "Non-blocking" means the writer is never back-pressured. A word arriving while the buffer is full is dropped and counted. Four instances feed each output daemon, one per source input port.

## Interface

Parameters:
- DEPTH, 8: number of 32-bit entries; power of two, at least 2.
- PTR_W, 3: log2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- IN_WORD  in  32  word from the input side.
- IN_VALID  in  1  IN_WORD is valid this cycle.
- POP  in  1  output daemon has consumed the current head word.
- NOBLOCKOBUF_OUT  out  33  bit 32 is the valid flag (1 = not empty); bits 31:0 are the head word, or 32'h0 when empty.
- FULL  out  1  count == DEPTH.
- EMPTY  out  1  count == 0.
- COUNT  out  PTR_W+1  number of stored words.
- DROP_COUNT  out  16  number of dropped words; saturates at 16'hFFFF.

## Operation

- Storage is a DEPTH-entry array with write pointer wr_ptr, read pointer rd_ptr (both PTR_W bits, wrapping modulo DEPTH) and an explicit count register.
- Reset (asserting rst, at any time, including mid-packet): wr_ptr, rd_ptr, count and DROP_COUNT go to 0 immediately.
  - NOBLOCKOBUF_OUT = 33'h0, EMPTY = 1, FULL = 0, COUNT = 0.
  - Array contents are don't-care.
- Push condition: IN_VALID && (!FULL || do_pop).
  - Action: write mem[wr_ptr] <= IN_WORD, then wr_ptr increments.
- Drop condition: IN_VALID && FULL && !do_pop.
  - The word is discarded and DROP_COUNT increments, saturating at 16'hFFFF.
  - No other state changes.
- Pop: do_pop = POP && !EMPTY; on do_pop, rd_ptr increments.
  - POP while empty is ignored and is not an error.
- Count update: count += push - do_pop, so a simultaneous push and pop leaves count unchanged.
- Output (combinational from registered state):
  - NOBLOCKOBUF_OUT = EMPTY ? 33'h0 : {1'b1, mem[rd_ptr]}.
  - FULL, EMPTY and COUNT are decoded from count.
- Ordering: words leave in exactly the order they were accepted; dropped words never appear on the output.

## Timing

- Write-to-output latency is 1 cycle: a word pushed at edge k appears on NOBLOCKOBUF_OUT (valid = 1) after edge k, if the buffer was empty.
- Pop takes effect at the edge: the next word, or 33'h0, is presented after the same edge at which POP was sampled high.
- Throughput: one push and one pop per cycle, sustained.
- Boundary cases:
  - Empty buffer with IN_VALID and POP in the same cycle: push is accepted, pop is ignored, count becomes 1.
  - Full buffer with IN_VALID and POP in the same cycle: both happen, no drop, count stays DEPTH, FULL stays 1.
  - Full buffer with IN_VALID and no POP: drop.
  - Pointer wrap: DEPTH-1 -> 0 with no gap or duplicate.
  - DROP_COUNT at 16'hFFFF stays at 16'hFFFF.
- Reset is asynchronous on assertion. It must be released synchronously to clk by the system; the block itself does not synchronize deassertion.

## Test plan

- Reset with IN_VALID = 1 and IN_WORD = 32'h03000501 held -> while rst = 1, NOBLOCKOBUF_OUT = 33'h0, EMPTY = 1, DROP_COUNT = 0. After release and one edge -> NOBLOCKOBUF_OUT = 33'h103000501.
- Push 32, 10, 7, 128, 200 on consecutive cycles with POP = 0, then pop once per cycle:
  - Before popping: COUNT = 5.
  - While popping: output sequence 33'h100000020, 33'h10000000A, 33'h100000007, 33'h100000080, 33'h1000000C8, then 33'h0.
  - After the last pop: EMPTY = 1.
- Fill with 8 words (1..8), then push 9 and 10 with POP = 0 -> FULL = 1, DROP_COUNT = 2. Drain -> output 1..8 only.
- With the buffer full, push 9 with POP = 1 in the same cycle -> no drop, COUNT stays 8. Drain order is 2..9.
- Continuous push and pop of 20 words -> pointers wrap twice, output matches input order, COUNT stays at 1 throughout, DROP_COUNT = 0.
- Assert rst mid-stream with 3 words stored -> NOBLOCKOBUF_OUT = 33'h0 before the next edge. After release, push 32'hABCD -> output 33'h10000ABCD; no stale words appear.
